pc_sequencer: RTL

Control FSM that sequences the program counter for the single-issue rv32i core. It requests an instruction fetch, hands the fetched instruction to execute, and waits for execute to complete. It then drives the one-cycle PC opcode that advances the PC register (sequential, JAL, JALR or branch) and counts retired instructions. It sits between the instruction-memory port, the decode/execute stage and the PC register. It also halts the core on system instructions, illegal control classes, fetch timeouts and (optionally) misaligned targets.

---
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Fetch/execute/update control FSM that drives the PC opcode for the
//           rv32i core. Optional target alignment check: PC_SEQ_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
module pc_sequencer #(
    parameter int XLEN          = 32,
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    output logic             o_imem_req,
    input  logic             i_imem_ack,
    output logic             o_exec_valid,
    input  logic             i_exec_done,
    input  logic [2:0]       i_ctrl_class,
    input  logic             i_branch_taken,
    input  logic [XLEN-1:0]  i_target,
    output logic [2:0]       o_pc_op,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [1:0]       o_fault,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [2:0] c_PC_STOP   = 3'd0;
    localparam logic [2:0] c_PC_INCR   = 3'd1;
    localparam logic [2:0] c_PC_JAL    = 3'd2;
    localparam logic [2:0] c_PC_JALR   = 3'd3;
    localparam logic [2:0] c_PC_BRANCH = 3'd4;

    localparam logic [1:0] c_FAULT_NONE    = 2'd0;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'd2;
    localparam logic [1:0] c_FAULT_ALIGN   = 2'd3;

    localparam int              c_TO_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_op;
    logic [2:0]         w_next_op;
    logic [1:0]         r_fault;
    logic [1:0]         w_next_fault;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_TO_W-1:0]  w_next_to_cnt;
    logic [CNT_W-1:0]   r_retired;
    logic [CNT_W-1:0]   w_next_retired;
    logic               w_misaligned;
    logic               w_unused_target;

    assign w_unused_target = ^i_target;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    // Only control transfers that actually redirect the PC are checked.
    assign w_misaligned = ((i_ctrl_class == 3'd1) ||
                           (i_ctrl_class == 3'd2) ||
                           ((i_ctrl_class == 3'd3) && i_branch_taken)) &&
                          (i_target[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_op      <= c_PC_STOP;
            r_fault   <= c_FAULT_NONE;
            r_to_cnt  <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next_state;
            r_op      <= w_next_op;
            r_fault   <= w_next_fault;
            r_to_cnt  <= w_next_to_cnt;
            r_retired <= w_next_retired;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_op      = r_op;
        w_next_fault   = r_fault;
        w_next_to_cnt  = r_to_cnt;
        w_next_retired = r_retired;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state  = ST_FETCH;
                    w_next_to_cnt = '0;
                end
            end

            ST_FETCH: begin
                // An ack arriving on the last allowed cycle still wins.
                if (i_imem_ack) begin
                    w_next_state  = ST_EXEC;
                    w_next_to_cnt = '0;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_next_state  = ST_HALT;
                    w_next_fault  = c_FAULT_TIMEOUT;
                    w_next_to_cnt = '0;
                end else begin
                    w_next_to_cnt = r_to_cnt + 1'b1;
                end
            end

            ST_EXEC: begin
                if (i_exec_done) begin
                    if (i_ctrl_class == 3'd4) begin
                        w_next_state = ST_HALT;
                        w_next_fault = c_FAULT_NONE;
                    end else if (i_ctrl_class > 3'd4) begin
                        w_next_state = ST_HALT;
                        w_next_fault = c_FAULT_ILLEGAL;
                    end else if (w_misaligned) begin
                        w_next_state = ST_HALT;
                        w_next_fault = c_FAULT_ALIGN;
                    end else begin
                        w_next_state = ST_UPDATE;
                        case (i_ctrl_class)
                            3'd1:    w_next_op = c_PC_JAL;
                            3'd2:    w_next_op = c_PC_JALR;
                            3'd3:    w_next_op = i_branch_taken ? c_PC_BRANCH : c_PC_INCR;
                            default: w_next_op = c_PC_INCR;
                        endcase
                    end
                end
            end

            ST_UPDATE: begin
                w_next_state = ST_FETCH;
                if (r_retired != {CNT_W{1'b1}}) begin
                    w_next_retired = r_retired + 1'b1;
                end
            end

            ST_HALT: begin
                w_next_state = ST_HALT;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_pc_op      = (r_state == ST_UPDATE) ? r_op : c_PC_STOP;
    assign o_state      = r_state;
    assign o_imem_req   = (r_state == ST_FETCH);
    assign o_exec_valid = (r_state == ST_EXEC);
    assign o_halted     = (r_state == ST_HALT);
    assign o_fault      = r_fault;
    assign o_retired    = r_retired;

endmodule
`default_nettype wire
